pq_scheduler: RTL and testbench
===============================

Name: pq_scheduler

Overview:
Controller that shares one 6-entry sorted priority queue between NREQ insert requesters and one pop consumer.
- Arbitrates insert vs pop and drives the queue's newVal/loadIn/shiftOut/clear controls.
- Tracks occupancy and applies full/empty back-pressure.
- Sits between client blocks and the queue; it is the only driver of the queue's control pins.

Parameters:
W, 8, data width (matches queue width)
NREQ, 4, number of insert requesters
DEPTH, 6, queue capacity
STARVE_MAX, 8, cycles an eligible insert may lose to pop before insert is forced

Ports:
ck  input  1  clock, rising edge
reset_L  input  1  asynchronous active-low reset
ins_req  input  NREQ  insert request per requester, held until granted
ins_val  input  NREQ*W  flattened values, requester i at bits [i*W +: W]
ins_gnt  output  NREQ  one-hot insert grant, combinational
pop_req  input  1  pop request, held until granted
pop_gnt  output  1  pop grant, combinational
pop_rsp_valid  output  1  popped value valid, one-cycle pulse
pop_rsp_data  output  W  popped value
flush_req  input  1  discard queue contents
flush_done  output  1  one-cycle pulse when flush completes
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  $clog2(DEPTH+1)  current occupancy
pq_newVal  output  W  to queue newVal
pq_loadIn  output  1  to queue loadIn
pq_shiftOut  output  1  to queue shiftOut
pq_clear  output  1  to queue clear
pq_top  input  W  from queue top

Behaviour:
- FSM states: INIT, RUN, FLUSH.
- Reset (async): state=INIT; count=0; rr pointer=0; starve_cnt=0; pop_rsp_valid=0; pop_rsp_data=0; flush_done=0. Combinational outputs are 0 in reset.
- INIT: assert pq_clear for exactly one cycle, then go to RUN. No grants.
- RUN, flush_req=1: go to FLUSH. No grants this cycle.
- FLUSH (one cycle): pq_clear=1; count<=0; flush_done pulses on the following cycle; return to RUN. No grants.
- RUN eligibility:
  - pop_ok = pop_req & ~empty
  - ins_ok = |ins_req & ~full
- At most one queue operation per cycle. pq_loadIn and pq_shiftOut are never both 1.
- Priority when both are eligible: pop wins, unless starve_cnt >= STARVE_MAX; then insert wins.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) when ins_ok but not granted.
  - Cleared on insert grant, or when ins_ok=0.
- Insert grant:
  - Round-robin over ins_req starting at the rr pointer.
  - ins_gnt[i]=1, pq_newVal=ins_val[i], pq_loadIn=1.
  - count+1 at the edge; rr pointer <= i+1 mod NREQ.
- Pop grant:
  - pop_gnt=1, pq_shiftOut=1.
  - pop_rsp_data <= pq_top at the edge; pop_rsp_valid=1 in the next cycle only; count-1.
  - Latency: 1 cycle.
- pq_newVal=0 whenever pq_loadIn=0.
- Full: no ins_gnt, so the queue never drops its smallest entry. Empty: no pop_gnt.
- Value 0 is a legal insert. It is counted, and when popped it returns 0.
- Reset mid-operation: pending pop_rsp_valid and flush_done are dropped immediately; FSM re-enters INIT.

Optional Feature:
PQ_SCHED_STATS_EN
- Defined: adds outputs stat_ins (16b), stat_pop (16b) and stat_hwm ($clog2(DEPTH+1)).
  - stat_ins and stat_pop are saturating counts of granted inserts and pops.
  - stat_hwm is the maximum count seen.
  - All three reset to 0 and are cleared in FLUSH.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package pq_sched_pkg: state enum {INIT, RUN, FLUSH}, default DEPTH=6, count width function.
- One sub-module, pq_rr_arbiter: NREQ-wide round-robin arbiter. Inputs: req vector, pointer, enable. Outputs: one-hot grant, grant index.

Test Plan:
1. Reset release -> pq_clear=1 for exactly 1 cycle, empty=1, count=0, no grants during INIT.
2. ins_req=4'b0111 with values 5, 9, 3 held; pop_req=0 -> grants 0, 1, 2 on consecutive cycles; count=3. Then pop_req held -> pop_rsp_data 9, 5, 3 on successive pulses; empty=1.
3. Six inserts, then a 7th ins_req held -> full=1, ins_gnt=0, pq_loadIn=0 until a pop. After the pop, the 7th is granted the next cycle.
4. STARVE_MAX=2, count=6, pop_req and ins_req[1] both held:
   - pop granted in cycles 1-3 (cycle 1 insert is ineligible because full).
   - cycle 4 grants insert; starve_cnt returns to 0; count sequence 5, 4, 3, 4.
5. count=4, flush_req with pop_req=1 -> no pop_gnt, pq_clear 1 cycle, count=0, flush_done pulse, stats cleared if enabled.
6. Pop granted, then reset_L=0 before the next edge -> pop_rsp_valid=0 immediately; after release the INIT clear is seen.

Source files
------------

// File: rtl/pq_sched_pkg.sv
// rtl/pq_sched_pkg.sv - shared types and helpers for the priority-queue scheduler
//   Contents: state_t (INIT/RUN/FLUSH), DEFAULT_DEPTH, cnt_width() occupancy width helper.
package pq_sched_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH = 6;

  // Bits needed to hold an occupancy from 0 to depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pq_rr_arbiter.sv
// rtl/pq_rr_arbiter.sv - NREQ-wide round-robin arbiter
//   Ports: req   in  NREQ  request vector
//          ptr   in  IW    requester index searched first
//          en    in  1     grant permitted this cycle
//          gnt   out NREQ  one-hot grant (zero when en=0 or no request)
//          idx   out IW    index of the granted requester (0 when no grant)
module pq_rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic          found;
  logic [IW-1:0] cand;

  // Walk the requesters starting at ptr, wrapping modulo NREQ; first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((32'(ptr) + 32'(k)) % 32'(NREQ));
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/pq_scheduler.sv
// rtl/pq_scheduler.sv - arbitrates inserts and pops onto one sorted priority queue
//   Optional build macro: PQ_SCHED_STATS_EN (adds stat_ins, stat_pop, stat_hwm).
//   Ports: ck, reset_L                       clock, async active-low reset
//          ins_req/ins_val/ins_gnt           insert requesters, flattened values, one-hot grant
//          pop_req/pop_gnt                   pop request and grant
//          pop_rsp_valid/pop_rsp_data        popped value, one cycle after the grant
//          flush_req/flush_done              discard contents, completion pulse
//          full/empty/count                  occupancy status
//          pq_newVal/pq_loadIn/pq_shiftOut/pq_clear/pq_top   queue control and top value
module pq_scheduler
  import pq_sched_pkg::*;
#(
  parameter int W          = 8,
  parameter int NREQ       = 4,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int STARVE_MAX = 8,
  localparam int CW        = cnt_width(DEPTH)
) (
  input  logic              ck,
  input  logic              reset_L,
  input  logic [NREQ-1:0]   ins_req,
  input  logic [NREQ*W-1:0] ins_val,
  output logic [NREQ-1:0]   ins_gnt,
  input  logic              pop_req,
  output logic              pop_gnt,
  output logic              pop_rsp_valid,
  output logic [W-1:0]      pop_rsp_data,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic [W-1:0]      pq_newVal,
  output logic              pq_loadIn,
  output logic              pq_shiftOut,
  output logic              pq_clear,
  input  logic [W-1:0]      pq_top
`ifdef PQ_SCHED_STATS_EN
  ,
  output logic [15:0]       stat_ins,
  output logic [15:0]       stat_pop,
  output logic [CW-1:0]     stat_hwm
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [SW-1:0] starve_cnt;

  logic          run;
  logic          ins_ok;
  logic          pop_ok;
  logic          starved;
  logic          do_ins;
  logic          do_pop;
  logic [IW-1:0] arb_idx;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  // Grants only in RUN and never in the cycle a flush is requested; the
  // reset_L term keeps every combinational output low while held in reset.
  assign run     = reset_L && (state == RUN) && !flush_req;
  assign ins_ok  = run && (|ins_req) && !full;
  assign pop_ok  = run && pop_req && !empty;
  assign starved = (starve_cnt >= SW'(STARVE_MAX));

  // Pop normally wins; a starved insert takes the slot.
  assign do_ins  = ins_ok && (!pop_ok || starved);
  assign do_pop  = pop_ok && !do_ins;

  pq_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (ins_req),
    .ptr (rr_ptr),
    .en  (do_ins),
    .gnt (ins_gnt),
    .idx (arb_idx)
  );

  assign pop_gnt     = do_pop;
  assign pq_shiftOut = do_pop;
  assign pq_loadIn   = do_ins;
  assign pq_newVal   = do_ins ? ins_val[32'(arb_idx)*W +: W] : '0;
  assign pq_clear    = reset_L && ((state == INIT) || (state == FLUSH));

  always_ff @(posedge ck or negedge reset_L) begin
    if (!reset_L) begin
      state         <= INIT;
      count         <= '0;
      rr_ptr        <= '0;
      starve_cnt    <= '0;
      pop_rsp_valid <= 1'b0;
      pop_rsp_data  <= '0;
      flush_done    <= 1'b0;
    end else begin
      pop_rsp_valid <= 1'b0;
      flush_done    <= 1'b0;

      // ins_ok is zero outside RUN, so this also clears the counter there.
      if (ins_ok && !do_ins)
        starve_cnt <= starved ? starve_cnt : starve_cnt + SW'(1);
      else
        starve_cnt <= '0;

      case (state)
        INIT: state <= RUN;
        RUN: begin
          if (flush_req)
            state <= FLUSH;
          if (do_ins) begin
            count  <= count + CW'(1);
            rr_ptr <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
          end else if (do_pop) begin
            count         <= count - CW'(1);
            pop_rsp_data  <= pq_top;
            pop_rsp_valid <= 1'b1;
          end
        end
        FLUSH: begin
          count      <= '0;
          flush_done <= 1'b1;
          state      <= RUN;
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef PQ_SCHED_STATS_EN
  always_ff @(posedge ck or negedge reset_L) begin
    if (!reset_L) begin
      stat_ins <= '0;
      stat_pop <= '0;
      stat_hwm <= '0;
    end else if (state == FLUSH) begin
      stat_ins <= '0;
      stat_pop <= '0;
      stat_hwm <= '0;
    end else begin
      if (do_ins && stat_ins != 16'hFFFF)
        stat_ins <= stat_ins + 16'd1;
      if (do_pop && stat_pop != 16'hFFFF)
        stat_pop <= stat_pop + 16'd1;
      if (count > stat_hwm)
        stat_hwm <= count;
    end
  end
`endif

endmodule

// File: tb/tb_pq_scheduler.sv
// tb/tb_pq_scheduler.sv - directed self-checking bench for pq_scheduler
module tb_pq_scheduler;

  logic        ck;
  logic        reset_L;
  logic [3:0]  ins_req;
  logic [31:0] ins_val;
  logic [3:0]  ins_gnt;
  logic        pop_req;
  logic        pop_gnt;
  logic        pop_rsp_valid;
  logic [7:0]  pop_rsp_data;
  logic        flush_req;
  logic        flush_done;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic [7:0]  pq_newVal;
  logic        pq_loadIn;
  logic        pq_shiftOut;
  logic        pq_clear;
  logic [7:0]  pq_top;
`ifdef PQ_SCHED_STATS_EN
  logic [15:0] stat_ins;
  logic [15:0] stat_pop;
  logic [2:0]  stat_hwm;
`endif

  int errors = 0;
  int checks = 0;

  pq_scheduler #(.W(8), .NREQ(4), .DEPTH(6), .STARVE_MAX(2)) dut (
    .ck            (ck),
    .reset_L       (reset_L),
    .ins_req       (ins_req),
    .ins_val       (ins_val),
    .ins_gnt       (ins_gnt),
    .pop_req       (pop_req),
    .pop_gnt       (pop_gnt),
    .pop_rsp_valid (pop_rsp_valid),
    .pop_rsp_data  (pop_rsp_data),
    .flush_req     (flush_req),
    .flush_done    (flush_done),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .pq_newVal     (pq_newVal),
    .pq_loadIn     (pq_loadIn),
    .pq_shiftOut   (pq_shiftOut),
    .pq_clear      (pq_clear),
    .pq_top        (pq_top)
`ifdef PQ_SCHED_STATS_EN
    ,
    .stat_ins      (stat_ins),
    .stat_pop      (stat_pop),
    .stat_hwm      (stat_hwm)
`endif
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Behavioural 6-entry sorted queue, largest value at the top.
  logic [7:0] qm [0:5];
  int         qn = 0;

  always @(posedge ck) begin : qmodel
    logic [7:0] t [0:5];
    int tn;
    int p;
    t  = qm;
    tn = qn;
    if (pq_clear) begin
      tn = 0;
    end else if (pq_shiftOut && tn > 0) begin
      for (int i = 0; i < 5; i++) t[i] = t[i+1];
      tn = tn - 1;
    end else if (pq_loadIn) begin
      p = 0;
      while (p < tn && t[p] >= pq_newVal) p++;
      if (p < 6) begin
        for (int i = 5; i > p; i--) t[i] = t[i-1];
        t[p] = pq_newVal;
        if (tn < 6) tn = tn + 1;
      end
    end
    qm <= t;
    qn <= tn;
  end

  assign pq_top = (qn > 0) ? qm[0] : 8'd0;

  task automatic tick;
    @(negedge ck);
  endtask

  task automatic test_reset;
    reset_L   = 1'b0;
    ins_req   = 4'b0000;
    ins_val   = 32'h0;
    pop_req   = 1'b0;
    flush_req = 1'b0;
    repeat (3) tick();
    #1;
    checks++; if (pq_clear !== 1'b0) begin errors++; $display("FAIL rst_clear_in_reset got=%0d exp=0", pq_clear); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%0d exp=1", empty); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (pop_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_pop_valid got=%0d exp=0", pop_rsp_valid); end
    // Release with an insert already requested: INIT must not grant it.
    tick();
    ins_req = 4'b1111;
    ins_val = 32'h44332211;
    reset_L = 1'b1;
    #1;
    checks++; if (pq_clear !== 1'b1) begin errors++; $display("FAIL init_clear got=%0d exp=1", pq_clear); end
    checks++; if (ins_gnt !== 4'b0000) begin errors++; $display("FAIL init_no_gnt got=%b exp=0000", ins_gnt); end
    checks++; if (pq_loadIn !== 1'b0) begin errors++; $display("FAIL init_no_load got=%0d exp=0", pq_loadIn); end
    tick();
    ins_req = 4'b0000;
    #1;
    checks++; if (pq_clear !== 1'b0) begin errors++; $display("FAIL init_clear_one_cycle got=%0d exp=0", pq_clear); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL init_count got=%0d exp=0", count); end
  endtask

  task automatic test_insert_pop;
    logic [3:0] req_seq [0:2];
    logic [3:0] gnt_seq [0:2];
    logic [7:0] val_seq [0:2];
    logic [7:0] pop_seq [0:2];
    req_seq = '{4'b0111, 4'b0110, 4'b0100};
    gnt_seq = '{4'b0001, 4'b0010, 4'b0100};
    val_seq = '{8'd5, 8'd9, 8'd3};
    pop_seq = '{8'd9, 8'd5, 8'd3};
    ins_val = {8'd0, 8'd3, 8'd9, 8'd5};
    for (int k = 0; k < 3; k++) begin
      tick();
      ins_req = req_seq[k];
      #1;
      checks++; if (ins_gnt !== gnt_seq[k]) begin errors++; $display("FAIL ins_gnt[%0d] got=%b exp=%b", k, ins_gnt, gnt_seq[k]); end
      checks++; if (pq_newVal !== val_seq[k] || pq_loadIn !== 1'b1) begin errors++; $display("FAIL ins_newval[%0d] got=%0d/%0d exp=%0d/1", k, pq_newVal, pq_loadIn, val_seq[k]); end
    end
    tick();
    ins_req = 4'b0000;
    pop_req = 1'b1;
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL ins_count got=%0d exp=3", count); end
    checks++; if (pop_gnt !== 1'b1 || pq_shiftOut !== 1'b1 || pq_newVal !== 8'd0) begin errors++; $display("FAIL pop_first got=%0d/%0d/%0d exp=1/1/0", pop_gnt, pq_shiftOut, pq_newVal); end
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      checks++; if (pop_rsp_valid !== 1'b1 || pop_rsp_data !== pop_seq[k]) begin errors++; $display("FAIL pop_data[%0d] got=%0d/%0d exp=1/%0d", k, pop_rsp_valid, pop_rsp_data, pop_seq[k]); end
    end
    checks++; if (empty !== 1'b1 || pop_gnt !== 1'b0) begin errors++; $display("FAIL pop_empty got=%0d/%0d exp=1/0", empty, pop_gnt); end
    tick();
    pop_req = 1'b0;
    #1;
    checks++; if (pop_rsp_valid !== 1'b0) begin errors++; $display("FAIL pop_valid_pulse got=%0d exp=0", pop_rsp_valid); end
  endtask

  task automatic test_full;
    for (int k = 0; k < 6; k++) begin
      tick();
      ins_req = 4'b1000;
      ins_val[31:24] = 8'(10 * (k + 1));
      #1;
      checks++; if (ins_gnt !== 4'b1000) begin errors++; $display("FAIL fill_gnt[%0d] got=%b exp=1000", k, ins_gnt); end
    end
    tick();
    ins_req = 4'b0010;
    ins_val[15:8] = 8'd7;
    #1;
    checks++; if (full !== 1'b1 || count !== 3'd6) begin errors++; $display("FAIL full_flag got=%0d/%0d exp=1/6", full, count); end
    for (int k = 0; k < 2; k++) begin
      checks++; if (ins_gnt !== 4'b0000 || pq_loadIn !== 1'b0 || pq_newVal !== 8'd0) begin errors++; $display("FAIL full_block[%0d] got=%b/%0d/%0d exp=0000/0/0", k, ins_gnt, pq_loadIn, pq_newVal); end
      tick();
      #1;
    end
    pop_req = 1'b1;
    #1;
    checks++; if (pop_gnt !== 1'b1 || ins_gnt !== 4'b0000) begin errors++; $display("FAIL full_pop got=%0d/%b exp=1/0000", pop_gnt, ins_gnt); end
    tick();
    pop_req = 1'b0;
    #1;
    checks++; if (pop_rsp_data !== 8'd60) begin errors++; $display("FAIL full_pop_data got=%0d exp=60", pop_rsp_data); end
    checks++; if (ins_gnt !== 4'b0010 || pq_newVal !== 8'd7) begin errors++; $display("FAIL full_late_gnt got=%b/%0d exp=0010/7", ins_gnt, pq_newVal); end
    tick();
    ins_req = 4'b0000;
    #1;
    checks++; if (count !== 3'd6) begin errors++; $display("FAIL full_refill_count got=%0d exp=6", count); end
  endtask

  task automatic test_starve;
    logic       pg_seq [0:3];
    logic [3:0] ig_seq [0:3];
    logic [2:0] cnt_seq [0:3];
    pg_seq  = '{1'b1, 1'b1, 1'b1, 1'b0};
    ig_seq  = '{4'b0000, 4'b0000, 4'b0000, 4'b0010};
    cnt_seq = '{3'd6, 3'd5, 3'd4, 3'd3};
    tick();
    pop_req = 1'b1;
    ins_req = 4'b0010;
    ins_val[15:8] = 8'd25;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (pop_gnt !== pg_seq[k] || ins_gnt !== ig_seq[k] || count !== cnt_seq[k]) begin errors++; $display("FAIL starve_c%0d got=%0d/%b/%0d exp=%0d/%b/%0d", k + 1, pop_gnt, ins_gnt, count, pg_seq[k], ig_seq[k], cnt_seq[k]); end
      tick();
    end
    // Counter must have been cleared by the forced insert: pop wins again.
    ins_val[15:8] = 8'd26;
    #1;
    checks++; if (count !== 3'd4 || pop_gnt !== 1'b1 || ins_gnt !== 4'b0000) begin errors++; $display("FAIL starve_cleared got=%0d/%0d/%b exp=4/1/0000", count, pop_gnt, ins_gnt); end
    tick();
    pop_req = 1'b0;
    #1;
    checks++; if (pop_rsp_data !== 8'd25 || ins_gnt !== 4'b0010) begin errors++; $display("FAIL starve_tail got=%0d/%b exp=25/0010", pop_rsp_data, ins_gnt); end
    tick();
    ins_req = 4'b0000;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL starve_final_count got=%0d exp=4", count); end
  endtask

  task automatic test_flush;
    tick();
    flush_req = 1'b1;
    pop_req   = 1'b1;
    #1;
    checks++; if (pop_gnt !== 1'b0 || pq_shiftOut !== 1'b0 || pq_clear !== 1'b0) begin errors++; $display("FAIL flush_req_cycle got=%0d/%0d/%0d exp=0/0/0", pop_gnt, pq_shiftOut, pq_clear); end
    tick();
    flush_req = 1'b0;
    #1;
    checks++; if (pq_clear !== 1'b1 || pop_gnt !== 1'b0 || flush_done !== 1'b0) begin errors++; $display("FAIL flush_state got=%0d/%0d/%0d exp=1/0/0", pq_clear, pop_gnt, flush_done); end
    tick();
    #1;
    checks++; if (flush_done !== 1'b1 || count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_done got=%0d/%0d/%0d exp=1/0/1", flush_done, count, empty); end
    checks++; if (pq_clear !== 1'b0 || pop_gnt !== 1'b0) begin errors++; $display("FAIL flush_after got=%0d/%0d exp=0/0", pq_clear, pop_gnt); end
`ifdef PQ_SCHED_STATS_EN
    checks++; if (stat_ins !== 16'd0 || stat_pop !== 16'd0 || stat_hwm !== 3'd0) begin errors++; $display("FAIL flush_stats got=%0d/%0d/%0d exp=0/0/0", stat_ins, stat_pop, stat_hwm); end
`endif
    tick();
    pop_req = 1'b0;
    #1;
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_done_pulse got=%0d exp=0", flush_done); end
  endtask

  task automatic test_reset_mid;
    tick();
    ins_req = 4'b0001;
    ins_val[7:0] = 8'd0;
    #1;
    checks++; if (ins_gnt !== 4'b0001 || pq_loadIn !== 1'b1 || pq_newVal !== 8'd0) begin errors++; $display("FAIL zero_insert got=%b/%0d/%0d exp=0001/1/0", ins_gnt, pq_loadIn, pq_newVal); end
    tick();
    ins_req = 4'b0000;
    pop_req = 1'b1;
    #1;
    checks++; if (count !== 3'd1 || pop_gnt !== 1'b1) begin errors++; $display("FAIL zero_pop got=%0d/%0d exp=1/1", count, pop_gnt); end
    tick();
    pop_req = 1'b0;
    #1;
    checks++; if (pop_rsp_valid !== 1'b1 || pop_rsp_data !== 8'd0) begin errors++; $display("FAIL zero_pop_data got=%0d/%0d exp=1/0", pop_rsp_valid, pop_rsp_data); end
    reset_L = 1'b0;
    #1;
    checks++; if (pop_rsp_valid !== 1'b0 || pq_clear !== 1'b0) begin errors++; $display("FAIL mid_reset_drop got=%0d/%0d exp=0/0", pop_rsp_valid, pq_clear); end
    tick();
    tick();
    reset_L = 1'b1;
    #1;
    checks++; if (pq_clear !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL mid_reset_init got=%0d/%0d exp=1/0", pq_clear, count); end
    tick();
    #1;
    checks++; if (pq_clear !== 1'b0) begin errors++; $display("FAIL mid_reset_init_len got=%0d exp=0", pq_clear); end
  endtask

  initial begin
    test_reset();
    test_insert_pop();
    test_full();
    test_starve();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
